// File: rtl/memory_access_pkg.sv
// utils_top: constants and types shared by the memory-access stage.
//   OP_*    : 7-bit major opcodes the stage decodes
//   BUBBLE  : canonical no-op instruction (addi x0, x0, 0)
//   F3_*    : load funct3 codes; stores reuse 000/001/010
//   state_t : memory-access FSM state encoding
package utils_top;

    localparam logic [6:0]  OP_LOAD   = 7'b000_0011;
    localparam logic [6:0]  OP_STORE  = 7'b010_0011;
    localparam logic [6:0]  OP_BRANCH = 7'b110_0011;
    localparam logic [31:0] BUBBLE    = 32'h0000_0013;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic [31:0] inst);
        return (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: data-memory bus between the stage and the memory.
//   dmem_req   : request, held for the whole access
//   dmem_we    : 1 = store, 0 = load
//   dmem_addr  : word address, [1:0] = 0
//   dmem_be    : byte enables
//   dmem_wdat  : lane-replicated store data
//   dmem_ack   : access done; dmem_rdat valid in the same cycle
//   dmem_rdat  : load word
// master = memory-access stage, slave = memory.
interface memory_access_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdat;
    logic        dmem_ack;
    logic [31:0] dmem_rdat;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdat,
        input  dmem_ack, dmem_rdat
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdat,
        output dmem_ack, dmem_rdat
    );

endinterface

// File: rtl/memory_access_lsu_align.sv
// memory_access_lsu_align: purely combinational alignment logic.
//   acc_funct3/acc_addr_lo/acc_rd2 : access about to be issued
//   acc_legal                      : alignment / funct3 legality
//   acc_be, acc_wdat               : byte enables and replicated store data
//   ld_funct3/ld_addr_lo/ld_rdat   : captured load and returned word
//   ld_data                        : extracted, extended load result
module memory_access_lsu_align
    import utils_top::*;
(
    input  logic [2:0]  acc_funct3,
    input  logic [1:0]  acc_addr_lo,
    input  logic [31:0] acc_rd2,
    output logic        acc_legal,
    output logic [3:0]  acc_be,
    output logic [31:0] acc_wdat,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdat,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        acc_legal = 1'b0;
        acc_be    = 4'b0000;
        acc_wdat  = '0;
        case (acc_funct3)
            F3_LB, F3_LBU: begin
                acc_legal = 1'b1;
                acc_be    = 4'b0001 << acc_addr_lo;
                acc_wdat  = {4{acc_rd2[7:0]}};
            end
            F3_LH, F3_LHU: begin
                acc_legal = ~acc_addr_lo[0];
                acc_be    = acc_addr_lo[1] ? 4'b1100 : 4'b0011;
                acc_wdat  = {2{acc_rd2[15:0]}};
            end
            F3_LW: begin
                acc_legal = (acc_addr_lo == 2'b00);
                acc_be    = 4'b1111;
                acc_wdat  = acc_rd2;
            end
            default: ;
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extending.
    assign ld_shifted = ld_rdat >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_data = ld_rdat;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_LBU:  ld_data = {24'h00_0000, ld_shifted[7:0]};
            F3_LH:   ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_LHU:  ld_data = {16'h0000, ld_shifted[15:0]};
            default: ld_data = ld_rdat;
        endcase
    end

endmodule

// File: rtl/memory_access_top.sv
// memory_access_top: memory-access pipeline stage.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ma_inst/ma_dat/ma_rd2 : instruction, ALU result/address, store data
//   ma_stall              : hold request to execute
//   dmem                  : data-memory bus (master side)
//   wb_inst, wb_dat       : registered outputs to writeback
//   ma_fwd_we/dst/dat     : forwarding to decode
//   ma_misalign           : one-cycle pulse on an illegal memory op
module memory_access_top
    import utils_top::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            ma_inst,
    input  logic [31:0]            ma_dat,
    input  logic [31:0]            ma_rd2,
    output logic                   ma_stall,
    memory_access_if.master        dmem,
    output logic [31:0]            wb_inst,
    output logic [31:0]            wb_dat,
    output logic                   ma_fwd_we,
    output logic [4:0]             ma_fwd_dst,
    output logic [31:0]            ma_fwd_dat,
    output logic                   ma_misalign
);

    state_t      state_q, state_d;
    logic [31:0] inst_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [2:0]  funct3_q;

    logic        mem_op;
    logic        acc_legal;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdat;
    logic [31:0] ld_data;
    logic        start_access;
    logic [31:0] wb_inst_d;
    logic [31:0] wb_dat_d;
    logic        misalign_d;

    memory_access_lsu_align u_align (
        .acc_funct3  (ma_inst[14:12]),
        .acc_addr_lo (ma_dat[1:0]),
        .acc_rd2     (ma_rd2),
        .acc_legal   (acc_legal),
        .acc_be      (acc_be),
        .acc_wdat    (acc_wdat),
        .ld_funct3   (funct3_q),
        .ld_addr_lo  (addr_q[1:0]),
        .ld_rdat     (dmem.dmem_rdat),
        .ld_data     (ld_data)
    );

    assign mem_op       = is_mem_op(ma_inst);
    assign start_access = (state_q == IDLE) && mem_op && acc_legal;

    always_comb begin
        state_d    = state_q;
        wb_inst_d  = BUBBLE;
        wb_dat_d   = '0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_access) begin
                    state_d = ACCESS;
                end else if (mem_op) begin
                    misalign_d = 1'b1;
                end else begin
                    wb_inst_d = ma_inst;
                    wb_dat_d  = ma_dat;
                end
            end
            ACCESS: begin
                // dmem_ack only matters here; an ack seen in IDLE is ignored.
                if (dmem.dmem_ack) begin
                    state_d   = IDLE;
                    wb_inst_d = inst_q;
                    wb_dat_d  = we_q ? addr_q : ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated with rst_n so the stage never stalls execute while held in reset.
    assign ma_stall = rst_n & (start_access |
                               ((state_q == ACCESS) & ~dmem.dmem_ack));

    // Reset forces state_q to IDLE asynchronously, so the request drops at once.
    assign dmem.dmem_req  = (state_q == ACCESS);
    assign dmem.dmem_we   = we_q;
    assign dmem.dmem_addr = {addr_q[31:2], 2'b00};
    assign dmem.dmem_be   = be_q;
    assign dmem.dmem_wdat = wdat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            wb_inst     <= BUBBLE;
            wb_dat      <= '0;
            ma_misalign <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_inst     <= wb_inst_d;
            wb_dat      <= wb_dat_d;
            ma_misalign <= misalign_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the capture registers drive the memory bus directly, so they
        // are reset too; otherwise the bus would show X after reset.
        if (!rst_n) begin
            inst_q   <= BUBBLE;
            addr_q   <= '0;
            wdat_q   <= '0;
            be_q     <= 4'b0000;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
        end else if (start_access) begin
            inst_q   <= ma_inst;
            addr_q   <= ma_dat;
            wdat_q   <= acc_wdat;
            be_q     <= acc_be;
            we_q     <= (ma_inst[6:0] == OP_STORE);
            funct3_q <= ma_inst[14:12];
        end
    end

    // Stores, branches and bubbles write no register; x0 is never forwarded.
    assign ma_fwd_we  = (wb_inst[6:0] != OP_STORE) && (wb_inst[6:0] != OP_BRANCH) &&
                        (wb_inst != BUBBLE) && (wb_inst[11:7] != 5'd0);
    assign ma_fwd_dst = wb_inst[11:7];
    assign ma_fwd_dat = wb_dat;

endmodule

// File: tb/tb_memory_access_top.sv
module tb_memory_access_top;
    import utils_top::*;

    localparam logic [6:0] OP_ALU = 7'b011_0011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ma_inst = BUBBLE;
    logic [31:0] ma_dat = '0;
    logic [31:0] ma_rd2 = '0;
    logic        ma_stall;
    logic [31:0] wb_inst;
    logic [31:0] wb_dat;
    logic        ma_fwd_we;
    logic [4:0]  ma_fwd_dst;
    logic [31:0] ma_fwd_dat;
    logic        ma_misalign;

    memory_access_if dmem_bus ();

    memory_access_top dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ma_inst     (ma_inst),
        .ma_dat      (ma_dat),
        .ma_rd2      (ma_rd2),
        .ma_stall    (ma_stall),
        .dmem        (dmem_bus),
        .wb_inst     (wb_inst),
        .wb_dat      (wb_dat),
        .ma_fwd_we   (ma_fwd_we),
        .ma_fwd_dst  (ma_fwd_dst),
        .ma_fwd_dat  (ma_fwd_dat),
        .ma_misalign (ma_misalign)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {12'h000, 5'd1, f3, rd, op};
    endfunction

    function automatic bit model_legal(input logic [2:0] f3, input logic [31:0] addr);
        int lo;
        lo = int'(addr % 4);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) return (lo % 2) == 0;
        if (f3 == 3'd2) return lo == 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdat);
        logic [31:0] b, h;
        int sh;
        sh = 8 * int'(addr % 4);
        b  = (rdat >> sh) & 32'hFF;
        h  = (rdat >> sh) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return rdat;
        endcase
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int lo;
        lo = int'(addr % 4);
        if (f3 == 3'd0) return 32'd1 << lo;
        if (f3 == 3'd1) return 32'd3 << lo;
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdat(input logic [2:0] f3, input logic [31:0] rd2);
        if (f3 == 3'd0) return (rd2 & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (rd2 & 32'hFFFF) * 32'h0001_0001;
        return rd2;
    endfunction

    function automatic logic model_fwd_we(input logic [31:0] inst);
        return (inst[6:0] != OP_STORE) && (inst[6:0] != OP_BRANCH) &&
               (inst != BUBBLE) && (inst[11:7] != 5'd0);
    endfunction

    // Apply one instruction starting just after a rising edge; act as the
    // memory with 'delay' non-ack cycles before the ack. Returns aligned
    // just after a rising edge.
    task automatic apply_op(input string tag, input logic [31:0] inst, input logic [31:0] dat,
                            input logic [31:0] rd2, input int delay, input logic [31:0] rdat);
        logic       mem, legal, is_store;
        logic [2:0] f3;
        int         stalls;
        f3       = inst[14:12];
        is_store = (inst[6:0] == OP_STORE);
        mem      = (inst[6:0] == OP_LOAD) || is_store;
        legal    = mem && model_legal(f3, dat);
        ma_inst  = inst;
        ma_dat   = dat;
        ma_rd2   = rd2;
        @(negedge clk);
        if (!legal) begin
            check({tag, "/stall"}, ma_stall, 1'b0);
            check({tag, "/req"}, dmem_bus.dmem_req, 1'b0);
            @(posedge clk); #1;
            check({tag, "/req_after"}, dmem_bus.dmem_req, 1'b0);
            if (!mem) begin
                check({tag, "/wb_inst"}, wb_inst, inst);
                check({tag, "/wb_dat"}, wb_dat, dat);
                check({tag, "/misalign"}, ma_misalign, 1'b0);
                check({tag, "/fwd_we"}, ma_fwd_we, model_fwd_we(inst));
                check({tag, "/fwd_dst"}, ma_fwd_dst, inst[11:7]);
                check({tag, "/fwd_dat"}, ma_fwd_dat, dat);
            end else begin
                check({tag, "/wb_inst"}, wb_inst, BUBBLE);
                check({tag, "/wb_dat"}, wb_dat, 32'h0);
                check({tag, "/misalign"}, ma_misalign, 1'b1);
                check({tag, "/fwd_we"}, ma_fwd_we, 1'b0);
                ma_inst = BUBBLE;
                @(posedge clk); #1;
                check({tag, "/misalign_drop"}, ma_misalign, 1'b0);
            end
        end else begin
            stalls = 1;
            check({tag, "/stall0"}, ma_stall, 1'b1);
            check({tag, "/req0"}, dmem_bus.dmem_req, 1'b0);
            @(posedge clk); #1;
            for (int k = 0; k <= delay; k++) begin
                dmem_bus.dmem_ack  = (k == delay);
                dmem_bus.dmem_rdat = (k == delay) ? rdat : $urandom;
                @(negedge clk);
                if (ma_stall) stalls++;
                check({tag, "/req"}, dmem_bus.dmem_req, 1'b1);
                check({tag, "/addr"}, dmem_bus.dmem_addr, dat & 32'hFFFF_FFFC);
                check({tag, "/we"}, dmem_bus.dmem_we, is_store);
                if (is_store) begin
                    check({tag, "/be"}, dmem_bus.dmem_be, model_be(f3, dat));
                    check({tag, "/wdat"}, dmem_bus.dmem_wdat, model_wdat(f3, rd2));
                end
                @(posedge clk); #1;
                dmem_bus.dmem_ack = 1'b0;
                if (k < delay) check({tag, "/wb_wait"}, wb_inst, BUBBLE);
            end
            check({tag, "/stall_cycles"}, stalls, delay + 1);
            check({tag, "/wb_inst"}, wb_inst, inst);
            check({tag, "/wb_dat"}, wb_dat, is_store ? dat : model_load(f3, dat, rdat));
            check({tag, "/fwd_we"}, ma_fwd_we, model_fwd_we(inst));
            check({tag, "/req_done"}, dmem_bus.dmem_req, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] inst, addr, rd2, rdat;
        logic [2:0]  f3;
        int          kind;
        dmem_bus.dmem_ack  = 1'b0;
        dmem_bus.dmem_rdat = '0;

        // Reset state
        #12;
        check("rst/req", dmem_bus.dmem_req, 1'b0);
        check("rst/we", dmem_bus.dmem_we, 1'b0);
        check("rst/addr", dmem_bus.dmem_addr, 32'h0);
        check("rst/be", dmem_bus.dmem_be, 4'b0000);
        check("rst/wdat", dmem_bus.dmem_wdat, 32'h0);
        check("rst/wb_inst", wb_inst, BUBBLE);
        check("rst/wb_dat", wb_dat, 32'h0);
        check("rst/misalign", ma_misalign, 1'b0);
        check("rst/stall", ma_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        apply_op("lw", mk_inst(OP_LOAD, F3_LW, 5'd5), 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        apply_op("lb", mk_inst(OP_LOAD, F3_LB, 5'd6), 32'h103, 32'h0, 1, 32'h80FF_0000);
        apply_op("lbu", mk_inst(OP_LOAD, F3_LBU, 5'd7), 32'h103, 32'h0, 0, 32'h80FF_0000);
        apply_op("sh", mk_inst(OP_STORE, 3'b001, 5'd2), 32'h102, 32'h1234_ABCD, 0, 32'h0);
        check("sh/be_exact", dmem_bus.dmem_be, 4'b1100);
        check("sh/wdat_exact", dmem_bus.dmem_wdat, 32'hABCD_ABCD);
        apply_op("lh_mis", mk_inst(OP_LOAD, F3_LH, 5'd3), 32'h101, 32'h0, 0, 32'h0);
        apply_op("add", mk_inst(OP_ALU, 3'b000, 5'd9), 32'h0000_1234, 32'h0, 0, 32'h0);
        apply_op("bubble", BUBBLE, 32'h0, 32'h0, 0, 32'h0);

        // Stray ack while idle
        ma_inst = mk_inst(OP_ALU, 3'b000, 5'd4);
        ma_dat  = 32'h5555_AAAA;
        dmem_bus.dmem_ack  = 1'b1;
        dmem_bus.dmem_rdat = 32'hFFFF_FFFF;
        @(negedge clk);
        check("stray/req", dmem_bus.dmem_req, 1'b0);
        check("stray/stall", ma_stall, 1'b0);
        @(posedge clk); #1;
        dmem_bus.dmem_ack = 1'b0;
        check("stray/wb_inst", wb_inst, mk_inst(OP_ALU, 3'b000, 5'd4));
        check("stray/wb_dat", wb_dat, 32'h5555_AAAA);
        check("stray/req_after", dmem_bus.dmem_req, 1'b0);

        // Reset during ACCESS
        ma_inst = mk_inst(OP_LOAD, F3_LW, 5'd8);
        ma_dat  = 32'h200;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstacc/req_before", dmem_bus.dmem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstacc/req", dmem_bus.dmem_req, 1'b0);
        check("rstacc/stall", ma_stall, 1'b0);
        check("rstacc/addr", dmem_bus.dmem_addr, 32'h0);
        check("rstacc/wb_inst", wb_inst, BUBBLE);
        @(posedge clk); #1;
        ma_inst = mk_inst(OP_ALU, 3'b000, 5'd11);
        ma_dat  = 32'h77;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstacc/wb_inst_rel", wb_inst, BUBBLE);
        check("rstacc/req_rel", dmem_bus.dmem_req, 1'b0);
        @(posedge clk); #1;
        check("rstacc/idle_pass", wb_inst, mk_inst(OP_ALU, 3'b000, 5'd11));
        check("rstacc/idle_dat", wb_dat, 32'h77);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 4));
            addr = $urandom;
            rd2  = $urandom;
            rdat = $urandom;
            f3   = 3'($urandom_range(0, 7));
            case (kind)
                0:       inst = mk_inst(OP_LOAD, f3, 5'($urandom));
                1:       inst = mk_inst(OP_STORE, 3'($urandom_range(0, 3)), 5'($urandom));
                2:       inst = mk_inst(OP_ALU, f3, 5'($urandom));
                3:       inst = mk_inst(OP_BRANCH, f3, 5'($urandom));
                default: inst = BUBBLE;
            endcase
            apply_op("rand", inst, addr, rd2, int'($urandom_range(0, 3)), rdat);
        end
        apply_op("tail", BUBBLE, 32'h0, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/memory_access_top.md
MEMORY_ACCESS_TOP -- requirements
Module: memory_access_top

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset. All ports are listed below; clock and reset come first.
- clk  in  1  stage clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ma_inst  in  32  instruction from execute; equals BUBBLE on a branch flush
- ma_dat  in  32  ALU result; the effective address for loads and stores
- ma_rd2  in  32  store source data
- ma_stall  out  1  upstream hold; execute keeps ma_* constant while this is high
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdat  out  32  lane-replicated store data
- dmem_ack  in  1  memory done; dmem_rdat valid in the same cycle
- dmem_rdat  in  32  load word
- wb_inst  out  32  registered instruction to writeback
- wb_dat  out  32  registered result to writeback
- ma_fwd_we / ma_fwd_dst / ma_fwd_dat  out  1/5/32  forwarding to decode
- ma_misalign  out  1  one-cycle error pulse

Function
REQ-002 SHALL implement the state machine IDLE/ACCESS:
- IDLE -> ACCESS when ma_inst is OP_LOAD or OP_STORE and the access is legal (REQ-006); the instruction, address, data, be and funct3 are captured at that edge.
- ACCESS -> IDLE on the cycle dmem_ack = 1.
REQ-003 SHALL drive ma_stall = (IDLE & legal memory op) | (ACCESS & ~dmem_ack).
REQ-004 SHALL drive dmem_req = (state == ACCESS); dmem_addr, dmem_we, dmem_be and dmem_wdat SHALL come from the captured registers only.
REQ-005 SHALL update wb_inst and wb_dat on every clock edge as follows:
- non-memory op in IDLE: ma_inst / ma_dat (1-cycle latency).
- ACCESS with ack: captured instruction; load data per REQ-007, or the address for a store.
- otherwise: BUBBLE / 0.
- Minimum memory-op latency is 2 cycles; each cycle without ack adds one.
REQ-006 Legality rules, keyed on funct3, with a = address bits [1:0]:
- byte (000, 100) is always legal.
- half (001, 101) requires a[0] = 0.
- word (010) requires a = 00.
- any other funct3 is illegal.
REQ-007 Load extraction: select the byte or half by a; LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through.
REQ-008 Store encoding:
- SB: be = 0001 << a, wdat = byte replicated x4.
- SH: be = 0011 << (a[1]*2), wdat = half replicated x2.
- SW: be = 1111, wdat = ma_rd2.
REQ-009 An illegal memory op SHALL:
- issue no request;
- not stall;
- write BUBBLE to wb_inst;
- register ma_misalign = 1 for exactly one cycle.
REQ-010 ma_fwd_we = 1 only when wb_inst is not OP_STORE, OP_BRANCH or BUBBLE and wb_inst[11:7] != 0; ma_fwd_dst = wb_inst[11:7]; ma_fwd_dat = wb_dat.
REQ-011 dmem_ack received in IDLE SHALL be ignored.
REQ-012 A BUBBLE on ma_inst SHALL pass through in 1 cycle with no memory activity.

Reset
REQ-013 While rst_n = 0, the stage SHALL hold:
- state = IDLE;
- dmem_req = 0 and dmem_we = 0;
- dmem_addr, dmem_wdat and wb_dat = 0; dmem_be = 0000;
- wb_inst = BUBBLE;
- ma_misalign = 0 and ma_stall = 0.
REQ-014 Reset asserted during ACCESS SHALL drop dmem_req immediately and discard the pending access; no writeback results from it.

Structure
REQ-015 The shared package utils_top SHALL hold OP_LOAD, OP_STORE, OP_BRANCH, BUBBLE, the funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU (store reuses 000/001/010), and the state enum.
REQ-016 Alignment, byte-enable, replication and extension logic SHALL live in one combinational sub-module, memory_access_lsu_align. The FSM and all registers SHALL stay in the top.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- LW at 0x100, ack 3 cycles after req, rdat 0xDEADBEEF -> stall for 4 cycles, wb_dat = 0xDEADBEEF, ma_fwd_we = 1.
- LB at 0x103 with rdat 0x80FF_0000 -> wb_dat = 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x102, rd2 = 0x1234ABCD, ack on the first cycle -> be = 1100, wdat = 0xABCDABCD, we = 1, ma_fwd_we = 0.
- LH at 0x101 -> no req, ma_misalign pulses for 1 cycle, wb_inst = BUBBLE, no stall.
- ADD followed by a BUBBLE -> each reaches wb 1 cycle later; stray dmem_ack in IDLE has no effect.
- rst_n driven low during ACCESS -> dmem_req = 0 asynchronously; after release wb_inst = BUBBLE and state = IDLE.
